pixel_binarizer: RTL and testbench

- Consumes the 16-bit RGB565 pixel stream from the camera capture stage: pixel word, one-cycle valid strobe, and one-cycle frame-done strobe.
- Per pixel: computes 8-bit luma, thresholds it to one bit, and generates the linear frame-buffer write address from internal row/column counters.
- Output feeds the binary frame buffer BRAM used by the QR finder-pattern logic.
- Also flags frames with the wrong pixel count.

---
 rtl/pixel_binarizer.sv | 153 +++++++++++++++
 tb/tb_pixel_binarizer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_binarizer.sv
// RGB565 stream to 1-bit luma threshold with linear frame-buffer addressing.
// Two register stages; also flags frames whose pixel count differs from H*V.
module pixel_binarizer #(
  parameter int H_PIXELS       = 320,
  parameter int V_PIXELS       = 240,
  parameter int THRESH_DEFAULT = 128,
  parameter int ADDR_W         = $clog2(H_PIXELS * V_PIXELS)
) (
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  input  logic [15:0]       pixel_in,
  input  logic              pixel_valid_in,
  input  logic              frame_done_in,
  input  logic [7:0]        threshold_in,
  output logic              bin_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              bin_valid_out,
  output logic              frame_done_out,
  output logic              short_frame_out,
  output logic              long_frame_out
);

  localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int ROW_W = $clog2(V_PIXELS + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(V_PIXELS);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_thresh;
  logic              r_long_seen;

  logic              w_accept;
  logic              w_drop;
  logic              w_first_drop;
  logic [COL_W-1:0]  w_col_next;
  logic [ROW_W-1:0]  w_row_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [7:0]        w_r8;
  logic [7:0]        w_g8;
  logic [7:0]        w_b8;

  logic              r_s1_valid;
  logic [15:0]       r_s1_pr;
  logic [15:0]       r_s1_pg;
  logic [15:0]       r_s1_pb;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [7:0]        r_s1_thr;
  logic              r_s1_fd;
  logic              r_s1_short;
  logic              r_s1_long;

  logic [15:0]       w_sum;
  logic              w_light;

  // Row reaching V_PIXELS marks a completed frame; further pixels are dropped.
  always_comb begin
    w_accept     = pixel_valid_in && (r_row != ROW_END);
    w_drop       = pixel_valid_in && (r_row == ROW_END);
    w_first_drop = w_drop && !r_long_seen;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_addr_next  = r_addr;
    if (w_accept) begin
      w_addr_next = r_addr + ADDR_W'(1);
      if (r_col == COL_LAST) begin
        w_col_next = '0;
        w_row_next = r_row + ROW_W'(1);
      end else begin
        w_col_next = r_col + COL_W'(1);
      end
    end
    w_r8 = {pixel_in[15:11], pixel_in[15:13]};
    w_g8 = {pixel_in[10:5],  pixel_in[10:9]};
    w_b8 = {pixel_in[4:0],   pixel_in[4:2]};
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_thresh    <= 8'(THRESH_DEFAULT);
      r_long_seen <= 1'b0;
    end else if (frame_done_in) begin
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_thresh    <= threshold_in;
      r_long_seen <= 1'b0;
    end else begin
      r_col  <= w_col_next;
      r_row  <= w_row_next;
      r_addr <= w_addr_next;
      if (w_drop) r_long_seen <= 1'b1;
    end
  end

  // The threshold travels with each pixel so in-flight pixels keep the old one.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_pr    <= '0;
      r_s1_pg    <= '0;
      r_s1_pb    <= '0;
      r_s1_addr  <= '0;
      r_s1_thr   <= '0;
      r_s1_fd    <= 1'b0;
      r_s1_short <= 1'b0;
      r_s1_long  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_fd    <= frame_done_in;
      r_s1_short <= frame_done_in && (w_row_next != ROW_END);
      r_s1_long  <= w_first_drop;
      if (pixel_valid_in) begin
        r_s1_pr   <= 16'(w_r8) * 16'd77;
        r_s1_pg   <= 16'(w_g8) * 16'd150;
        r_s1_pb   <= 16'(w_b8) * 16'd29;
        r_s1_addr <= r_addr;
        r_s1_thr  <= r_thresh;
      end
    end
  end

  // (sum >> 8) >= thr is evaluated as sum >= thr * 256.
  always_comb begin
    w_sum   = r_s1_pr + r_s1_pg + r_s1_pb;
    w_light = (w_sum >= {r_s1_thr, 8'h00});
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      bin_out         <= 1'b0;
      addr_out        <= '0;
      bin_valid_out   <= 1'b0;
      frame_done_out  <= 1'b0;
      short_frame_out <= 1'b0;
      long_frame_out  <= 1'b0;
    end else begin
      bin_valid_out   <= r_s1_valid;
      frame_done_out  <= r_s1_fd;
      short_frame_out <= r_s1_short;
      long_frame_out  <= r_s1_long;
      if (r_s1_valid) begin
        bin_out  <= w_light;
        addr_out <= r_s1_addr;
      end
    end
  end

endmodule

// File: tb/tb_pixel_binarizer.sv
// Bench for pixel_binarizer: directed scenarios plus random traffic, all
// compared every cycle against a pixel-count based reference model.
module tb_pixel_binarizer;

  localparam int H       = 20;
  localparam int V       = 12;
  localparam int NPIX    = H * V;
  localparam int AW      = $clog2(NPIX);
  localparam int THR_DEF = 128;

  typedef struct packed {
    logic          valid;
    logic          bin;
    logic [AW-1:0] addr;
    logic          fd;
    logic          sh;
    logic          lg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   pix = '0;
  logic          pv  = 1'b0;
  logic          fdi = 1'b0;
  logic [7:0]    thr = 8'd128;
  logic          bin, bv, fdo, sh, lg;
  logic [AW-1:0] addr;

  int checks = 0;
  int errors = 0;

  exp_t          e_d1, e_d2;
  int            m_cnt;
  bit            m_long;
  int            m_thr;
  logic          m_last_bin;
  logic [AW-1:0] m_last_addr;

  always #5 clk = ~clk;

  pixel_binarizer #(
    .H_PIXELS(H),
    .V_PIXELS(V),
    .THRESH_DEFAULT(THR_DEF)
  ) dut (
    .clk_pixel_in(clk),
    .rst_in(rst),
    .pixel_in(pix),
    .pixel_valid_in(pv),
    .frame_done_in(fdi),
    .threshold_in(thr),
    .bin_out(bin),
    .addr_out(addr),
    .bin_valid_out(bv),
    .frame_done_out(fdo),
    .short_frame_out(sh),
    .long_frame_out(lg)
  );

  function automatic int luma(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = (r << 3) | (r >> 2);
    g = (g << 2) | (g >> 4);
    b = (b << 3) | (b >> 2);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  function automatic exp_t obs();
    return {bv, bin, addr, fdo, sh, lg};
  endfunction

  task automatic model_reset();
    m_cnt       = 0;
    m_long      = 0;
    m_thr       = THR_DEF;
    m_last_bin  = 1'b0;
    m_last_addr = '0;
    e_d1        = '0;
    e_d2        = '0;
  endtask

  // Drives one cycle, advances the model and returns the outputs expected now.
  task automatic step(input bit v, input logic [15:0] p, input bit f,
                      input logic [7:0] t, output exp_t e);
    exp_t n;
    pv = v; pix = p; fdi = f; thr = t;
    n = '0;
    n.bin  = m_last_bin;
    n.addr = m_last_addr;
    if (v) begin
      if (m_cnt < NPIX) begin
        n.valid     = 1'b1;
        n.bin       = (luma(p) >= m_thr);
        n.addr      = AW'(m_cnt);
        m_last_bin  = n.bin;
        m_last_addr = n.addr;
        m_cnt++;
      end else begin
        n.lg   = !m_long;
        m_long = 1;
      end
    end
    if (f) begin
      n.fd   = 1'b1;
      n.sh   = (m_cnt < NPIX);
      m_cnt  = 0;
      m_long = 0;
      m_thr  = int'(t);
    end
    @(posedge clk);
    e_d2 = e_d1;
    e_d1 = n;
    #1;
    pv  = 1'b0;
    fdi = 1'b0;
    e   = e_d2;
  endtask

  task automatic do_reset();
    rst = 1'b1; pv = 1'b0; fdi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== exp_t'('0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_first_pixel();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 16'hFFFF, 0, 8'd128, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL first_pixel c%0d: got %h expected %h", i, obs(), e);
      end
      if (i == 1) begin
        checks++;
        if (!(bv === 1'b1 && bin === 1'b1 && addr === '0)) begin
          errors++;
          $display("FAIL first_pixel_direct: got v=%b b=%b a=%0d expected v=1 b=1 a=0", bv, bin, addr);
        end
      end
    end
  endtask

  task automatic test_sequence();
    exp_t e;
    logic [15:0] seq [3];
    seq[0] = 16'h0000; seq[1] = 16'hF800; seq[2] = 16'h07E0;
    model_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(i < 3, (i < 3) ? seq[i] : 16'h0, 0, 8'd128, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL sequence c%0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_full_frame();
    exp_t e;
    step(0, 16'h0, 1, 8'd128, e);
    for (int i = 0; i < NPIX + 4; i++) begin
      if (i < NPIX) step(1, 16'($urandom), 0, 8'd128, e);
      else          step(0, 16'h0, (i == NPIX), 8'd128, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL full_frame c%0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_long_frame();
    exp_t e;
    int n_long = 0;
    for (int i = 0; i < NPIX + 8; i++) begin
      if (i < NPIX + 2)      step(1, 16'($urandom), 0, 8'd128, e);
      else if (i == NPIX + 3) step(0, 16'h0, 1, 8'd128, e);
      else if (i == NPIX + 4) step(1, 16'hFFFF, 0, 8'd128, e);
      else                    step(0, 16'h0, 0, 8'd128, e);
      if (lg === 1'b1) n_long++;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL long_frame c%0d: got %h expected %h", i, obs(), e);
      end
    end
    checks++;
    if (n_long != 1) begin
      errors++;
      $display("FAIL long_pulse_count: got %0d expected 1", n_long);
    end
  endtask

  task automatic test_short_frame();
    exp_t e;
    for (int i = 0; i < 106; i++) begin
      if (i < 100)      step(1, 16'($urandom), 0, 8'd128, e);
      else if (i == 100) step(0, 16'h0, 1, 8'd128, e);
      else if (i == 102) step(1, 16'h1234, 0, 8'd128, e);
      else               step(0, 16'h0, 0, 8'd128, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL short_frame c%0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_threshold();
    exp_t e;
    // (valid, frame_done, threshold_in) per cycle; pixel is always Y=149
    bit       tv [12];
    bit       tf [12];
    logic [7:0] tt [12];
    tv = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0};
    tf = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    tt = '{200, 200, 200, 200, 149, 149, 150, 150, 150, 150, 150, 150};
    for (int i = 0; i < 12; i++) begin
      step(tv[i], 16'h07E0, tf[i], tt[i], e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL threshold c%0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_coincident();
    exp_t e;
    step(0, 16'h0, 1, 8'd150, e);
    for (int i = 0; i < NPIX + 4; i++) begin
      if (i < NPIX - 1)       step(1, 16'($urandom), 0, 8'd150, e);
      else if (i == NPIX - 1) step(1, 16'h07E0, 1, 8'd100, e);
      else if (i == NPIX)     step(1, 16'h07E0, 0, 8'd100, e);
      else                    step(0, 16'h0, 0, 8'd100, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL coincident c%0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    for (int i = 0; i < 10; i++) step(1, 16'($urandom), 0, 8'd100, e);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 16'h07E0, 0, 8'd10, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_midframe c%0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, 16'($urandom), ($urandom % (NPIX + 40)) == 0,
           8'($urandom), e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL random c%0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_pixel();
    test_sequence();
    test_full_frame();
    test_long_frame();
    test_short_frame();
    test_threshold();
    test_coincident();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
